meatsquare_spawner: RTL and testbench
=====================================

# meatsquare_spawner

Consumer of the 7-bit LFSR random stream: turns random matches into meatsquare spawn requests. Watches the random value for a trigger pattern, captures the next random sample as the spawn column, and enforces a minimum gap between spawns. Queues requests in a small FIFO and hands them to the drawing/animation controller over a valid/ready handshake.

## Interface
- MATCH, 7'b1010111: trigger pattern compared against `rnd_in`.
- X_MAX, 119: largest legal spawn column. Legal range is 63..126.
- COOLDOWN, 32: cycles spent in COOLDOWN after each capture. Legal range is 1..1023.
- DEPTH, 4: FIFO entries. Fixed at 4.
- clock  input  1  system clock, all state on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  game running; low suppresses new spawns.
- rnd_valid  input  1  `rnd_in` holds a fresh random sample this cycle.
- rnd_in  input  7  random value from the LFSR.
- spawn_valid  output  1  FIFO non-empty.
- spawn_x  output  7  column of the FIFO head entry.
- spawn_ready  input  1  consumer accepts the head entry this cycle.
- fifo_count  output  3  entries held, 0..4.
- drop_cnt  output  8  spawns lost to overflow; saturates at 255.

## Operation
- FSM states: IDLE, ARM, COOLDOWN.
- IDLE → ARM when `enable && rnd_valid && rnd_in == MATCH`.
- ARM → COOLDOWN on the first cycle with `enable && rnd_valid`:
  - capture x = `rnd_in` if `rnd_in <= X_MAX`, else x = `rnd_in - (X_MAX+1)`;
  - push x into the FIFO;
  - load the cooldown counter with COOLDOWN-1.
- While in ARM, a `rnd_in` equal to MATCH is treated as an ordinary position sample.
- COOLDOWN:
  - counter decrements each cycle;
  - when the counter is 0, go to IDLE on the next edge;
  - MATCH values are ignored.
- `enable` low in ARM or COOLDOWN: next state IDLE, counter cleared to 0, no push.
- `enable` low in IDLE: stay in IDLE.
- FIFO is first-word-fall-through:
  - `spawn_valid = (fifo_count != 0)`;
  - `spawn_x` = head entry, or 0 when empty.
- Pop occurs when `spawn_valid && spawn_ready`. `spawn_ready` while empty is ignored.
- Push while full:
  - with a simultaneous pop, both happen and the count stays at 4;
  - without a pop, the entry is dropped and `drop_cnt` increments, stopping at 255.
- Push and pop on the same cycle at count 1..3: count unchanged, order preserved.
- The FIFO is unaffected by `enable`. The consumer can drain it while the game is paused.
- Read and write pointers are 2 bits and wrap modulo 4.

## Timing
- Reset values: state IDLE, counter 0, pointers 0, `fifo_count` 0, `spawn_valid` 0, `spawn_x` 0, `drop_cnt` 0.
- Reset acts asynchronously at any time, including mid-ARM or mid-COOLDOWN, and discards pending captures and queued entries.
- Match sampled at edge t: state is ARM after t.
- Position sample at edge t+k, with k ≥ 1 being the first `rnd_valid` cycle in ARM: entry is visible on `spawn_x`/`spawn_valid` immediately after t+k (same edge as the push).
- COOLDOWN lasts exactly COOLDOWN cycles.
- The earliest next match is sampled COOLDOWN+1 edges after the capture edge.
- The pop edge updates the head. The new `spawn_x` is valid after that edge.
- All outputs are registered or decode registered state only. No combinational path from inputs to outputs.

## Test plan
- Basic spawn: reset, `enable`=1, `rnd_valid`=1; drive `rnd_in`=0x57 then 0x2A, `spawn_ready`=0 → `spawn_valid`=1, `spawn_x`=0x2A, `fifo_count`=1 one edge after the 0x2A sample.
- Column remap: MATCH then `rnd_in`=0x7C (124) with X_MAX=119 → `spawn_x`=4. Position sample 0x77 (119) → `spawn_x`=119.
- Cooldown: COOLDOWN=32; drive MATCH on every cycle after a capture → no second entry until the match sampled 33 edges after the capture edge; exactly 2 entries after 40 cycles.
- Overflow: `spawn_ready`=0, perform 6 spawns → `fifo_count`=4, `drop_cnt`=2, entries are the first 4 columns in order. Then a 7th spawn with `spawn_ready`=1 on the push cycle → count stays 4, `drop_cnt` stays 2, head advances.
- Drain and wrap: continue from the overflow case; hold `spawn_ready`=1 → 4 pops in order, `spawn_valid` drops after the 4th pop. Then push 3 more → correct order across the pointer wrap.
- Reset/enable mid-operation:
  - deassert `enable` in ARM → no push, state IDLE;
  - assert `reset` low mid-COOLDOWN with 2 entries queued → all outputs return to reset values asynchronously, and a match after release is accepted immediately.

Source files
------------

// File: rtl/meatsquare_spawner.sv
// meatsquare_spawner: watches the LFSR stream for a trigger pattern, captures
// the following random sample as a spawn column, enforces a cooldown between
// spawns and queues requests in a 4-entry first-word-fall-through FIFO that is
// drained by the drawing/animation controller over a valid/ready handshake.
module meatsquare_spawner #(
    parameter logic [6:0] MATCH    = 7'b1010111,
    parameter int         X_MAX    = 119,
    parameter int         COOLDOWN = 32,
    parameter int         DEPTH    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       rnd_valid,
    input  logic [6:0] rnd_in,
    output logic       spawn_valid,
    output logic [6:0] spawn_x,
    input  logic       spawn_ready,
    output logic [2:0] fifo_count,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARM      = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_t;

    localparam logic [9:0] CD_LOAD  = 10'(COOLDOWN - 1);
    localparam logic [6:0] X_MAX_C  = 7'(X_MAX);
    localparam logic [6:0] X_WRAP_C = 7'(X_MAX + 1);
    localparam logic [2:0] FULL_C   = 3'(DEPTH);

    state_t      state_r, state_nx_s;
    logic [9:0]  cnt_r, cnt_nx_s;
    logic [6:0]  mem_r [4];
    logic [1:0]  wr_ptr_r, rd_ptr_r;
    logic [2:0]  count_r, count_nx_s;
    logic [7:0]  drop_r;
    logic [6:0]  col_s;
    logic        push_s, pop_s, full_s, wr_s, drop_s;

    // Fold out-of-range samples back into the legal column range.
    always_comb begin
        col_s = rnd_in;
        if (rnd_in <= X_MAX_C) begin
            col_s = rnd_in;
        end else begin
            col_s = rnd_in - X_WRAP_C;
        end
    end

    // Spawn FSM next-state, cooldown counter and push request.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        push_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && rnd_valid && (rnd_in == MATCH)) begin
                    state_nx_s = ST_ARM;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (!enable) begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = 10'd0;
                end else if (rnd_valid) begin
                    state_nx_s = ST_COOLDOWN;
                    cnt_nx_s   = CD_LOAD;
                    push_s     = 1'b1;
                end else begin
                    state_nx_s = ST_ARM;
                end
            end
            ST_COOLDOWN: begin
                if (!enable) begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = 10'd0;
                end else if (cnt_r == 10'd0) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    cnt_nx_s   = cnt_r - 10'd1;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = 10'd0;
            end
        endcase
    end

    // FSM state and cooldown counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 10'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // FIFO control: a full FIFO still accepts a push when the head leaves.
    always_comb begin
        full_s     = (count_r == FULL_C);
        pop_s      = (count_r != 3'd0) && spawn_ready;
        wr_s       = push_s && (!full_s || pop_s);
        drop_s     = push_s && full_s && !pop_s;
        count_nx_s = count_r;
        if (wr_s && !pop_s) begin
            count_nx_s = count_r + 3'd1;
        end else if (pop_s && !wr_s) begin
            count_nx_s = count_r - 3'd1;
        end else begin
            count_nx_s = count_r;
        end
    end

    // FIFO storage, pointers, occupancy and saturating drop counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[i] <= 7'd0;
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
            drop_r   <= 8'd0;
        end else begin
            if (wr_s) begin
                mem_r[wr_ptr_r] <= col_s;
                wr_ptr_r        <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            if (drop_s && (drop_r != 8'd255)) begin
                drop_r <= drop_r + 8'd1;
            end
            count_r <= count_nx_s;
        end
    end

    // Outputs decode registered FIFO state only.
    always_comb begin
        spawn_valid = (count_r != 3'd0);
        fifo_count  = count_r;
        drop_cnt    = drop_r;
        if (count_r != 3'd0) begin
            spawn_x = mem_r[rd_ptr_r];
        end else begin
            spawn_x = 7'd0;
        end
    end

endmodule

// File: tb/tb_meatsquare_spawner.sv
// Self-checking bench for meatsquare_spawner: scenario tasks drive stimulus,
// a scoreboard queue holds expected columns, a negedge monitor checks the
// FIFO head, occupancy and drop count against the model every cycle.
module tb_meatsquare_spawner;

    localparam logic [6:0] MATCH = 7'h57;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       rnd_valid = 1'b0;
    logic [6:0] rnd_in = 7'd0;
    logic       spawn_valid;
    logic [6:0] spawn_x;
    logic       spawn_ready = 1'b0;
    logic [2:0] fifo_count;
    logic [7:0] drop_cnt;

    int         vectors = 0;
    int         miscompares = 0;
    logic [6:0] exp_q[$];
    logic [7:0] model_drop = 8'd0;

    meatsquare_spawner dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .rnd_valid   (rnd_valid),
        .rnd_in      (rnd_in),
        .spawn_valid (spawn_valid),
        .spawn_x     (spawn_x),
        .spawn_ready (spawn_ready),
        .fifo_count  (fifo_count),
        .drop_cnt    (drop_cnt)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] col_of(input logic [6:0] v);
        if (v > 7'd119) return v - 7'd120;
        else return v;
    endfunction

    // Scoreboard monitor: compares outputs to the model mid-cycle, pops on handshake.
    always @(negedge clock) begin
        if (reset) begin
            vectors++;
            if (spawn_valid !== (exp_q.size() != 0)) begin
                miscompares++;
                $display("FAIL mon_valid: got %b want %b", spawn_valid, exp_q.size() != 0);
            end
            vectors++;
            if (fifo_count !== 3'(exp_q.size())) begin
                miscompares++;
                $display("FAIL mon_count: got %0d want %0d", fifo_count, exp_q.size());
            end
            vectors++;
            if (drop_cnt !== model_drop) begin
                miscompares++;
                $display("FAIL mon_drop: got %0d want %0d", drop_cnt, model_drop);
            end
            vectors++;
            if (exp_q.size() != 0) begin
                if (spawn_x !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL mon_head: got %0d want %0d", spawn_x, exp_q[0]);
                end
                if (spawn_ready) void'(exp_q.pop_front());
            end else begin
                if (spawn_x !== 7'd0) begin
                    miscompares++;
                    $display("FAIL mon_empty_x: got %0d want 0", spawn_x);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Match then position sample; the model push happens at the capture edge.
    task automatic spawn(input logic [6:0] pos, input logic rdy);
        enable    = 1'b1;
        rnd_valid = 1'b1;
        rnd_in    = MATCH;
        tick();
        rnd_in      = pos;
        spawn_ready = rdy;
        @(posedge clock);
        if (exp_q.size() < 4) exp_q.push_back(col_of(pos));
        else if (model_drop != 8'd255) model_drop++;
        #1;
        rnd_valid   = 1'b0;
        rnd_in      = 7'd0;
        spawn_ready = 1'b0;
    endtask

    task automatic cool();
        repeat (32) tick();
    endtask

    task automatic drain(input int n);
        spawn_ready = 1'b1;
        repeat (n) tick();
        spawn_ready = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        vectors++;
        if ({spawn_valid, spawn_x, fifo_count, drop_cnt} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b x=%0d c=%0d d=%0d want all 0",
                     spawn_valid, spawn_x, fifo_count, drop_cnt);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        spawn(7'h2A, 1'b0);
        vectors++;
        if (spawn_valid !== 1'b1 || spawn_x !== 7'h2A || fifo_count !== 3'd1) begin
            miscompares++;
            $display("FAIL basic_spawn: got v=%b x=%h c=%0d want v=1 x=2a c=1",
                     spawn_valid, spawn_x, fifo_count);
        end
        cool();
        drain(1);
    endtask

    task automatic test_remap();
        spawn(7'h7C, 1'b0);
        vectors++;
        if (spawn_x !== 7'd4) begin
            miscompares++;
            $display("FAIL remap_124: got %0d want 4", spawn_x);
        end
        cool();
        drain(1);
        spawn(7'h77, 1'b0);
        vectors++;
        if (spawn_x !== 7'd119) begin
            miscompares++;
            $display("FAIL remap_119: got %0d want 119", spawn_x);
        end
        cool();
        drain(1);
    endtask

    task automatic test_cooldown();
        enable    = 1'b1;
        rnd_valid = 1'b1;
        rnd_in    = MATCH;
        tick();
        rnd_in = 7'h11;
        @(posedge clock);
        exp_q.push_back(7'h11);
        #1;
        rnd_in = MATCH;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 34) exp_q.push_back(MATCH);
            if (k == 33 || k == 34 || k == 40) begin
                vectors++;
                if (fifo_count !== ((k == 33) ? 3'd1 : 3'd2)) begin
                    miscompares++;
                    $display("FAIL cooldown_k%0d: got %0d want %0d", k, fifo_count,
                             (k == 33) ? 1 : 2);
                end
            end
        end
        rnd_valid = 1'b0;
        cool();
        drain(2);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) begin
            spawn(7'h10 + 7'(i), 1'b0);
            cool();
        end
        vectors++;
        if (fifo_count !== 3'd4 || drop_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL overflow_fill: got c=%0d d=%0d want c=4 d=2", fifo_count, drop_cnt);
        end
        spawn(7'h16, 1'b1);
        vectors++;
        if (fifo_count !== 3'd4 || drop_cnt !== 8'd2 || spawn_x !== 7'h11) begin
            miscompares++;
            $display("FAIL overflow_pushpop: got c=%0d d=%0d x=%h want c=4 d=2 x=11",
                     fifo_count, drop_cnt, spawn_x);
        end
        cool();
    endtask

    task automatic test_drain_wrap();
        drain(4);
        vectors++;
        if (spawn_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_empty: got valid=%b want 0", spawn_valid);
        end
        for (int i = 0; i < 3; i++) begin
            spawn(7'h20 + 7'(i), 1'b0);
            cool();
        end
        vectors++;
        if (fifo_count !== 3'd3 || spawn_x !== 7'h20) begin
            miscompares++;
            $display("FAIL wrap_fill: got c=%0d x=%h want c=3 x=20", fifo_count, spawn_x);
        end
        drain(3);
    endtask

    task automatic test_enable_arm();
        enable    = 1'b1;
        rnd_valid = 1'b1;
        rnd_in    = MATCH;
        tick();
        enable = 1'b0;
        rnd_in = 7'h22;
        tick();
        enable = 1'b1;
        rnd_in = 7'h33;
        tick();
        vectors++;
        if (fifo_count !== 3'd0) begin
            miscompares++;
            $display("FAIL enable_arm_nopush: got %0d want 0", fifo_count);
        end
        spawn(7'h44, 1'b0);
        vectors++;
        if (fifo_count !== 3'd1 || spawn_x !== 7'h44) begin
            miscompares++;
            $display("FAIL enable_arm_rearm: got c=%0d x=%h want c=1 x=44", fifo_count, spawn_x);
        end
        cool();
        drain(1);
    endtask

    task automatic test_reset_mid();
        spawn(7'h05, 1'b0);
        cool();
        spawn(7'h06, 1'b0);
        repeat (5) tick();
        #2;
        reset = 1'b0;
        exp_q.delete();
        model_drop = 8'd0;
        #1;
        vectors++;
        if ({spawn_valid, spawn_x, fifo_count, drop_cnt} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_async: got v=%b x=%0d c=%0d d=%0d want all 0",
                     spawn_valid, spawn_x, fifo_count, drop_cnt);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        spawn(7'h09, 1'b0);
        vectors++;
        if (fifo_count !== 3'd1 || spawn_x !== 7'h09) begin
            miscompares++;
            $display("FAIL reset_rematch: got c=%0d x=%h want c=1 x=09", fifo_count, spawn_x);
        end
        cool();
        drain(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_remap();
        test_cooldown();
        test_overflow();
        test_drain_wrap();
        test_enable_arm();
        test_reset_mid();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
